// File: rtl/operand_stage.sv
// ----------------------------------------------------------------------------
// operand_stage
//
// Decode-to-execute stage of the 3-stage pipeline. Drives the register file
// read addresses, resolves both source operands (x0 forcing, then writeback
// bypass, then register file data), detects load-use hazards, and loads the
// EX pipeline register. Update priority on each edge:
// flush > hold > hazard bubble > advance.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   id_valid .. id_imm          decoded instruction from ID
//   rf_rs1_num, rf_rs2_num      register file read addresses (combinational)
//   rf_rs1_value, rf_rs2_value  register file read data (combinational)
//   wb_we, wb_rd, wb_value      writeback port, also the register file write
//   ex_flush                    taken branch/jump resolved in EX
//   ex_hold                     execute stalled on a multi-cycle op
//   id_stall                    hold fetch/decode this cycle
//   ex_valid .. ex_is_load      EX pipeline register contents
//   bubble_cnt                  saturating count of load-use bubbles
//
// FSM states: none. The only sequential state is the EX register and the
// bubble counter.
// ----------------------------------------------------------------------------
module operand_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_we,
    input  logic             id_is_load,
    input  logic [XLEN-1:0]  id_imm,

    output logic [RA_W-1:0]  rf_rs1_num,
    output logic [RA_W-1:0]  rf_rs2_num,
    input  logic [XLEN-1:0]  rf_rs1_value,
    input  logic [XLEN-1:0]  rf_rs2_value,

    input  logic             wb_we,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_value,

    input  logic             ex_flush,
    input  logic             ex_hold,

    output logic             id_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_reg_we,
    output logic             ex_is_load,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_ex_valid;
    logic [XLEN-1:0]  r_ex_pc;
    logic [XLEN-1:0]  r_ex_imm;
    logic [XLEN-1:0]  r_ex_op1;
    logic [XLEN-1:0]  r_ex_op2;
    logic [RA_W-1:0]  r_ex_rd;
    logic             r_ex_reg_we;
    logic             r_ex_is_load;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [XLEN-1:0]  w_rs1_val;
    logic [XLEN-1:0]  w_rs2_val;
    logic             w_ex_load_wr;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_hazard;
    logic             w_cnt_sat;

    assign rf_rs1_num = id_rs1;
    assign rf_rs2_num = id_rs2;

    // The register file writes on the clock edge, so a value being written
    // this cycle is only visible through the bypass. x0 wins over the bypass
    // so a writeback to x0 can never leak a non-zero value.
    always_comb begin
        w_rs1_val = rf_rs1_value;
        if (id_rs1 == '0) begin
            w_rs1_val = '0;
        end else if (wb_we && (wb_rd == id_rs1)) begin
            w_rs1_val = wb_value;
        end
    end

    always_comb begin
        w_rs2_val = rf_rs2_value;
        if (id_rs2 == '0) begin
            w_rs2_val = '0;
        end else if (wb_we && (wb_rd == id_rs2)) begin
            w_rs2_val = wb_value;
        end
    end

    // A load in EX only has its data at WB, one cycle too late for the
    // instruction behind it; one bubble lets the bypass cover the gap.
    assign w_ex_load_wr = r_ex_valid && r_ex_is_load && r_ex_reg_we && (r_ex_rd != '0);
    assign w_rs1_hit    = id_use_rs1 && (id_rs1 == r_ex_rd);
    assign w_rs2_hit    = id_use_rs2 && (id_rs2 == r_ex_rd);
    assign w_hazard     = w_ex_load_wr && id_valid && (w_rs1_hit || w_rs2_hit);

    // A flush discards the ID instruction upstream, so stalling it is moot.
    assign id_stall  = (w_hazard || ex_hold) && !ex_flush;
    assign w_cnt_sat = &r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_pc      <= '0;
            r_ex_imm     <= '0;
            r_ex_op1     <= '0;
            r_ex_op2     <= '0;
            r_ex_rd      <= '0;
            r_ex_reg_we  <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (ex_flush) begin
            r_ex_valid <= 1'b0;
        end else if (ex_hold) begin
            // Everything holds; a pending hazard is re-evaluated after release.
            r_ex_valid <= r_ex_valid;
        end else if (w_hazard) begin
            r_ex_valid <= 1'b0;
            if (!w_cnt_sat) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end else begin
            r_ex_valid   <= id_valid;
            r_ex_pc      <= id_pc;
            r_ex_imm     <= id_imm;
            r_ex_op1     <= w_rs1_val;
            r_ex_op2     <= w_rs2_val;
            r_ex_rd      <= id_rd;
            r_ex_reg_we  <= id_reg_we;
            r_ex_is_load <= id_is_load;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_pc      = r_ex_pc;
    assign ex_imm     = r_ex_imm;
    assign ex_op1     = r_ex_op1;
    assign ex_op2     = r_ex_op2;
    assign ex_rd      = r_ex_rd;
    assign ex_reg_we  = r_ex_reg_we;
    assign ex_is_load = r_ex_is_load;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_operand_stage
//
// Directed bench for operand_stage with a 2-bit bubble counter so saturation
// is reachable. Inputs change 1ns after the rising edge; combinational
// outputs are sampled after a short settle and registered outputs 1ns after
// the following edge.
// ----------------------------------------------------------------------------
module tb_operand_stage;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [RA_W-1:0]  id_rd;
    logic             id_reg_we;
    logic             id_is_load;
    logic [XLEN-1:0]  id_imm;
    logic [RA_W-1:0]  rf_rs1_num;
    logic [RA_W-1:0]  rf_rs2_num;
    logic [XLEN-1:0]  rf_rs1_value;
    logic [XLEN-1:0]  rf_rs2_value;
    logic             wb_we;
    logic [RA_W-1:0]  wb_rd;
    logic [XLEN-1:0]  wb_value;
    logic             ex_flush;
    logic             ex_hold;
    logic             id_stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_op1;
    logic [XLEN-1:0]  ex_op2;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_reg_we;
    logic             ex_is_load;
    logic [CNT_W-1:0] bubble_cnt;

    int n_total = 0;
    int n_bad   = 0;

    operand_stage #(
        .XLEN  (XLEN),
        .RA_W  (RA_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_we    (id_reg_we),
        .id_is_load   (id_is_load),
        .id_imm       (id_imm),
        .rf_rs1_num   (rf_rs1_num),
        .rf_rs2_num   (rf_rs2_num),
        .rf_rs1_value (rf_rs1_value),
        .rf_rs2_value (rf_rs2_value),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_value     (wb_value),
        .ex_flush     (ex_flush),
        .ex_hold      (ex_hold),
        .id_stall     (id_stall),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rd        (ex_rd),
        .ex_reg_we    (ex_reg_we),
        .ex_is_load   (ex_is_load),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic we,
                             input logic ld, input logic [31:0] imm);
        id_valid   = v;
        id_pc      = pc;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        id_rd      = rd;
        id_reg_we  = we;
        id_is_load = ld;
        id_imm     = imm;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] val);
        wb_we    = we;
        wb_rd    = rd;
        wb_value = val;
    endtask

    initial begin
        int exp_cnt;

        rst_n        = 1'b0;
        ex_flush     = 1'b0;
        ex_hold      = 1'b0;
        rf_rs1_value = '0;
        rf_rs2_value = '0;
        set_instr(1'b1, 32'h1234, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b1, 32'h99);
        set_wb(1'b0, 5'd0, 32'h0);

        // Reset state
        tick();
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_op1", ex_op1, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_ex_is_load", {31'd0, ex_is_load}, 32'd0);
        chk("rst_bubble_cnt", {30'd0, bubble_cnt}, 32'd0);
        chk("rst_id_stall", {31'd0, id_stall}, 32'd0);

        // x0 forcing beats a writeback to x0
        rst_n        = 1'b1;
        set_instr(1'b1, 32'h100, 5'd0, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 32'h7);
        rf_rs1_value = 32'hDEADBEEF;
        rf_rs2_value = 32'h33;
        set_wb(1'b1, 5'd0, 32'h55);
        settle();
        chk("rf_rs1_num", {27'd0, rf_rs1_num}, 32'd0);
        chk("rf_rs2_num", {27'd0, rf_rs2_num}, 32'd3);
        tick();
        chk("x0_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("x0_ex_op1", ex_op1, 32'd0);
        chk("x0_ex_op2", ex_op2, 32'h33);
        chk("x0_ex_pc", ex_pc, 32'h100);
        chk("x0_ex_imm", ex_imm, 32'h7);
        chk("x0_ex_rd", {27'd0, ex_rd}, 32'd1);

        // WB bypass on rs2, then same stimulus without writeback
        set_instr(1'b1, 32'h104, 5'd0, 1'b0, 5'd5, 1'b1, 5'd2, 1'b1, 1'b0, 32'h0);
        rf_rs2_value = 32'h11;
        set_wb(1'b1, 5'd5, 32'h22);
        tick();
        chk("byp_ex_op2", ex_op2, 32'h22);
        set_wb(1'b0, 5'd5, 32'h22);
        tick();
        chk("nobyp_ex_op2", ex_op2, 32'h11);

        // Load-use: lw x7 then consumer of x7 on rs1
        set_instr(1'b1, 32'h200, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0);
        tick();
        chk("lw_ex_is_load", {31'd0, ex_is_load}, 32'd1);
        chk("lw_ex_rd", {27'd0, ex_rd}, 32'd7);
        set_instr(1'b1, 32'h204, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h0);
        rf_rs1_value = 32'hBAD;
        settle();
        chk("lu_id_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_cnt", {30'd0, bubble_cnt}, 32'd1);
        set_wb(1'b1, 5'd7, 32'h777);
        settle();
        chk("lu_stall_drop", {31'd0, id_stall}, 32'd0);
        tick();
        chk("lu_adv_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_adv_pc", ex_pc, 32'h204);
        chk("lu_adv_op1", ex_op1, 32'h777);
        chk("lu_adv_cnt", {30'd0, bubble_cnt}, 32'd1);

        // Use flags gate the hazard
        set_wb(1'b0, 5'd0, 32'h0);
        set_instr(1'b1, 32'h300, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0);
        tick();
        set_instr(1'b1, 32'h304, 5'd7, 1'b0, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0);
        settle();
        chk("nouse_id_stall", {31'd0, id_stall}, 32'd0);

        // Flush beats hold and hazard
        id_use_rs1 = 1'b1;
        ex_hold    = 1'b1;
        ex_flush   = 1'b1;
        settle();
        chk("fl_id_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_bubble_cnt", {30'd0, bubble_cnt}, 32'd1);
        ex_flush = 1'b0;
        ex_hold  = 1'b0;

        // Hold for three cycles with new ID values, then release
        set_instr(1'b1, 32'h400, 5'd3, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 32'h40);
        rf_rs1_value = 32'hA1;
        rf_rs2_value = 32'hA2;
        tick();
        chk("hd_pre_pc", ex_pc, 32'h400);
        set_instr(1'b1, 32'h404, 5'd3, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0, 32'h44);
        rf_rs1_value = 32'hB1;
        rf_rs2_value = 32'hB2;
        ex_hold      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hd_id_stall", {31'd0, id_stall}, 32'd1);
            tick();
            chk("hd_ex_pc", ex_pc, 32'h400);
            chk("hd_ex_op1", ex_op1, 32'hA1);
            chk("hd_ex_op2", ex_op2, 32'hA2);
        end
        ex_hold = 1'b0;
        settle();
        chk("hd_rel_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("hd_rel_pc", ex_pc, 32'h404);
        chk("hd_rel_op1", ex_op1, 32'hB1);
        chk("hd_rel_op2", ex_op2, 32'hB2);
        chk("hd_rel_imm", ex_imm, 32'h44);

        // Hold with a pending rs2 hazard: no bubble while held
        set_instr(1'b1, 32'h500, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 32'h0);
        tick();
        set_instr(1'b1, 32'h504, 5'd0, 1'b0, 5'd9, 1'b1, 5'd12, 1'b1, 1'b0, 32'h0);
        ex_hold = 1'b1;
        tick();
        chk("hh_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("hh_ex_pc", ex_pc, 32'h500);
        chk("hh_bubble_cnt", {30'd0, bubble_cnt}, 32'd1);
        ex_hold = 1'b0;
        settle();
        chk("hh_rel_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("hh_rel_valid", {31'd0, ex_valid}, 32'd0);
        chk("hh_rel_cnt", {30'd0, bubble_cnt}, 32'd2);

        // Three more hazards: five total, counter saturates at 3
        exp_cnt = 2;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 32'h600, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 32'h0);
            tick();
            set_instr(1'b1, 32'h604, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 32'h0);
            tick();
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            chk("sat_bubble_cnt", {30'd0, bubble_cnt}, exp_cnt[31:0]);
        end

        // id_valid=0 loads an empty slot
        set_instr(1'b0, 32'h700, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("inv_ex_valid", {31'd0, ex_valid}, 32'd0);

        // Reset mid-stall
        set_instr(1'b1, 32'h800, 5'd1, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 32'h0);
        tick();
        set_instr(1'b1, 32'h804, 5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 32'h0);
        settle();
        chk("mr_pre_stall", {31'd0, id_stall}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("mr_bubble_cnt", {30'd0, bubble_cnt}, 32'd0);
        chk("mr_ex_pc", ex_pc, 32'd0);
        chk("mr_id_stall", {31'd0, id_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Decode-to-execute stage of the 3-stage pipeline.
- Drives the register file read addresses and receives the read data combinationally.
- Applies writeback bypass and x0 forcing, detects load-use hazards and inserts bubbles.
- Registers operands and control into the EX pipeline register, with flush/hold handling and a saturating bubble counter.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-number width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- id_valid  in  1  decoded instruction present
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2  in  RA_W  source register numbers
- id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2
- id_rd  in  RA_W  destination register
- id_reg_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_imm  in  XLEN  decoded immediate
- rf_rs1_num, rf_rs2_num  out  RA_W  register file read addresses
- rf_rs1_value, rf_rs2_value  in  XLEN  register file read data
- wb_we  in  1  writeback valid, same signal as the register file write enable
- wb_rd  in  RA_W  writeback register
- wb_value  in  XLEN  writeback data
- ex_flush  in  1  taken branch/jump resolved in EX
- ex_hold  in  1  execute stalled (multi-cycle op)
- id_stall  out  1  hold fetch/decode this cycle
- ex_valid  out  1  EX register holds a live instruction
- ex_pc, ex_imm  out  XLEN  registered copies
- ex_op1, ex_op2  out  XLEN  resolved operands
- ex_rd  out  RA_W  registered destination
- ex_reg_we, ex_is_load  out  1  registered control
- bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n=0 at clock edge): all ex_* outputs 0, bubble_cnt 0. id_stall is combinational; it is 0 while ex_valid=0.
- rf_rs1_num = id_rs1 and rf_rs2_num = id_rs2, combinational. The register file writes on the clock edge, so same-cycle data is not visible without bypass.
- Operand resolution, per source, in priority order:
  - rs==0 -> 0.
  - wb_we & wb_rd==rs -> wb_value.
  - Otherwise rf value.
- ex_op2 carries the resolved rs2 value. The immediate is passed separately on ex_imm.
- Load-use hazard, hz = ex_valid & ex_is_load & ex_reg_we & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Registers whose use flag is 0 never trigger hz.
- id_stall = (hz | ex_hold) & ~ex_flush.
- Per-edge update priority: flush > hold > hazard > advance.
  - flush: ex_valid<=0; the other ex_* fields are don't-care. The ID instruction is discarded by upstream.
  - hold (no flush): all ex_* registers keep their values.
  - hazard (no flush, no hold): ex_valid<=0 (bubble); bubble_cnt increments unless at all-ones.
  - advance: ex_* <= resolved id_* fields; ex_valid<=id_valid.
- Latency: 1 cycle ID->EX. A load-use pair costs exactly 1 bubble. On the following cycle the load is in WB and the operand arrives through the bypass.
- ex_hold with a pending hazard: no bubble is counted while held. The hazard is re-evaluated after the hold releases.
- When id_valid=0, the register is loaded with ex_valid=0. Captured fields are don't-care; a bench must not check them.
- bubble_cnt saturates at 2^CNT_W-1 and is cleared only by reset.
- Reset asserted mid-stall: state clears on that edge, and id_stall drops because ex_valid=0.

Test Plan:
- x0 read: id_rs1=0, rf_rs1_value=32'hDEADBEEF, wb_we=1 with wb_rd=0 -> ex_op1=0 next cycle.
- WB bypass: id_rs2=5, rf_rs2_value=32'h11, wb_we=1, wb_rd=5, wb_value=32'h22 -> ex_op2=32'h22. Same stimulus with wb_we=0 -> ex_op2=32'h11.
- Load-use: lw x7 in EX, next instr uses rs1=7 -> id_stall=1 for 1 cycle, ex_valid=0 bubble, bubble_cnt=1. Then the instruction advances with ex_op1 taken from the WB bypass of x7.
- Flush priority: ex_flush=1 concurrent with hz=1 and ex_hold=1 -> id_stall=0, ex_valid=0, bubble_cnt unchanged.
- Hold: ex_hold=1 for 3 cycles with new id_* values -> ex_pc/ex_op1/ex_op2 unchanged, id_stall=1. Release -> the new instruction captured.
- Reset/saturation: CNT_W=2, force 5 hazards -> bubble_cnt=3. rst_n=0 for 1 edge -> bubble_cnt=0, ex_valid=0.
